// File: rtl/pmem_burst_responder_pkg.sv
// Shared types for the burst-memory responder: beat/line containers, FSM states, op encoding.
package pmem_types;

  localparam int BEAT_IDX_W = 2;

  typedef logic [63:0]      beat_t;
  typedef beat_t [3:0]      line_t;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} pmem_state_e;
  typedef enum logic {OP_READ, OP_WRITE} pmem_op_e;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: LINES lines of four 64-bit beats, one comb read port and one write port.
module pmem_line_array
  import pmem_types::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = 6
) (
  input  logic                  clk_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  input  logic [BEAT_IDX_W-1:0] rd_beat_i,
  output beat_t                 rd_data_o,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [BEAT_IDX_W-1:0] wr_beat_i,
  input  beat_t                 wr_data_i
);

  // Deliberately unreset: contents behave like DRAM and survive rst.
  line_t mem_q [LINES];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i][wr_beat_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i][rd_beat_i];

endmodule

// File: rtl/pmem_burst_responder.sv
// Fixed-latency burst memory model answering line reads/writes with four pmem_resp beats.
module pmem_burst_responder
  import pmem_types::*;
#(
  parameter int LINES   = 64,
  parameter int LATENCY = 4,
  parameter int BURSTS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        busy,
  output logic        protocol_err
);

  localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0]      LAT_LOAD  = CNT_W'(LAT_M1);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURSTS - 1);

  pmem_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  pmem_op_e                op_q, op_d;
  logic [26:0]             addr_q, addr_d;
  logic                    err_q, err_d;
  logic                    resp_q, busy_q;
  beat_t                   rdata_q, rdata_d;
  beat_t                   rd_beat;
  logic                    op_held, op_other, viol, we;
  logic                    unused_addr_lo;

  assign unused_addr_lo = ^pmem_address[4:0];

  assign op_held  = (op_q == OP_READ) ? pmem_read  : pmem_write;
  assign op_other = (op_q == OP_READ) ? pmem_write : pmem_read;
  assign viol     = !op_held || op_other || (pmem_address[31:5] != addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    op_d    = op_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          // Simultaneous read+write is served as a read.
          op_d    = pmem_read ? OP_READ : OP_WRITE;
          addr_d  = pmem_address[31:5];
          cnt_d   = LAT_LOAD;
          beat_d  = '0;
          state_d = (LATENCY == 0) ? BURST : WAIT;
          if (pmem_read && pmem_write) err_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = BURST;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      BURST: begin
        if (beat_q == LAST_BEAT) state_d = RECOVER;
        else                     beat_d  = beat_q + BEAT_IDX_W'(1);
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if ((state_q == WAIT || state_q == BURST) && viol) err_d = 1'b1;
  end

  // Read port is addressed with next-state index/beat so rdata can be registered.
  assign rdata_d = (state_d == BURST && op_d == OP_READ) ? rd_beat : '0;
  assign we      = (state_q == BURST) && (op_q == OP_WRITE);

  pmem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i     (clk),
    .rd_idx_i  (addr_d[IDX_W-1:0]),
    .rd_beat_i (beat_d),
    .rd_data_o (rd_beat),
    .we_i      (we),
    .wr_idx_i  (addr_q[IDX_W-1:0]),
    .wr_beat_i (beat_q),
    .wr_data_i (pmem_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      resp_q  <= (state_d == BURST);
      busy_q  <= (state_d != IDLE);
      rdata_q <= rdata_d;
    end
  end

  assign pmem_resp    = resp_q;
  assign pmem_rdata   = rdata_q;
  assign busy         = busy_q;
  assign protocol_err = err_q;

endmodule
